// File: rtl/rns_mod_sub_12.sv
// Nibble-serial modular subtractor (a - b) mod MOD with correction pass.
// Optional operand range check enabled by RNS_SUB_RANGE_CHECK_EN.
module rns_mod_sub_12 #(
    parameter int           W   = 12,
    parameter logic [W-1:0] MOD = 12'd4095
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         wrapped,
    output logic         err
);

    localparam int N  = W / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        CORR,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   result_q, result_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           bor_q, bor_d;
    logic           wrapped_q, wrapped_d;
    logic           err_q, err_d;

    logic [3:0]     a_nib, b_nib, r_nib, m_nib;
    logic [4:0]     diff, sum;
    logic           last;
    logic           range_bad;

`ifdef RNS_SUB_RANGE_CHECK_EN
    assign range_bad = (a >= MOD) || (b >= MOD);
`else
    assign range_bad = 1'b0;
`endif

    // Select the active nibble of each operand and of the modulus
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        r_nib = '0;
        m_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[i*4 +: 4];
                b_nib = b_q[i*4 +: 4];
                r_nib = r_q[i*4 +: 4];
                m_nib = MOD[i*4 +: 4];
            end
        end
        diff = {1'b0, a_nib} - {1'b0, b_nib} - {4'd0, bor_q};
        sum  = {1'b0, r_nib} + {1'b0, m_nib} + {4'd0, bor_q};
        last = (idx_q == IW'(N - 1));
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        result_d  = result_q;
        idx_d     = idx_q;
        bor_d     = bor_q;
        wrapped_d = wrapped_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (range_bad) begin
                        state_d   = DONE;
                        result_d  = '0;
                        wrapped_d = 1'b0;
                        err_d     = 1'b1;
                    end else begin
                        state_d = SUB;
                        a_d     = a;
                        b_d     = b;
                        r_d     = '0;
                        bor_d   = 1'b0;
                        idx_d   = '0;
                    end
                end
            end
            SUB: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) r_d[i*4 +: 4] = diff[3:0];
                end
                bor_d = diff[4];
                idx_d = idx_q + 1'b1;
                if (last) begin
                    idx_d = '0;
                    if (diff[4]) begin
                        state_d = CORR;
                        bor_d   = 1'b0;
                    end else begin
                        state_d   = DONE;
                        result_d  = r_d;
                        wrapped_d = 1'b0;
                    end
                end
            end
            CORR: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) r_d[i*4 +: 4] = sum[3:0];
                end
                bor_d = sum[4];
                idx_d = idx_q + 1'b1;
                // Final carry-out is dropped: the sum wraps modulo 2^W
                if (last) begin
                    idx_d     = '0;
                    state_d   = DONE;
                    result_d  = r_d;
                    wrapped_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            result_q  <= '0;
            idx_q     <= '0;
            bor_q     <= 1'b0;
            wrapped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            result_q  <= result_d;
            idx_q     <= idx_d;
            bor_q     <= bor_d;
            wrapped_q <= wrapped_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign wrapped   = wrapped_q;
    assign err       = err_q;

endmodule
